// File: rtl/transpose_sequencer.sv
// Schedules a job of tiles through a fixed-latency transpose unit into an external output buffer.
// Accept is combinational on in_valid & in_ready; buf_load follows LATENCY cycles later; credits stop overwrite.
module transpose_sequencer #(
  parameter int LATENCY   = 1,
  parameter int BUF_DEPTH = 2,
  parameter int TILE_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_transpose,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tu_ctrl,
  output logic              tu_rst,
  output logic              buf_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              buf_pop,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx
);

  localparam int CW = $clog2(BUF_DEPTH + LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [TILE_W-1:0]  tiles_q, tiles_d;
  logic [TILE_W-1:0]  acc_q, acc_d;
  logic [TILE_W-1:0]  popped_q, popped_d;
  logic [LATENCY-1:0] pipe_q, pipe_d;
  logic [CW-1:0]      buffered_q, buffered_d;
  logic [CW-1:0]      inflight;
  logic               accept;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(pipe_q[i]);
    end
  end

  // Credits come only from registered counts, so a same-cycle pop frees a slot one cycle later.
  assign in_ready  = (state_q == RUN) && (acc_q < tiles_q) && (CW'(BUF_DEPTH) > inflight + buffered_q);
  assign accept    = in_valid & in_ready;
  assign tu_ctrl   = accept & mode_q;
  assign tu_rst    = ~accept;
  assign buf_load  = pipe_q[LATENCY-1];
  assign out_valid = (buffered_q != '0);
  assign buf_pop   = out_valid & out_ready;
  assign out_last  = out_valid && (popped_q == tiles_q - TILE_W'(1));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign tile_idx  = acc_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tiles_d    = tiles_q;
    acc_d      = acc_q + TILE_W'(accept);
    popped_d   = popped_q + TILE_W'(buf_pop);
    buffered_d = buffered_q + CW'(buf_load) - CW'(buf_pop);
    pipe_d     = pipe_q << 1;
    pipe_d[0]  = accept;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = cfg_transpose;
          tiles_d  = cfg_tiles;
          acc_d    = '0;
          popped_d = '0;
          state_d  = (cfg_tiles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && (acc_q + TILE_W'(1) == tiles_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((pipe_q == '0) && (buffered_q == '0)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      tiles_q    <= '0;
      acc_q      <= '0;
      popped_q   <= '0;
      pipe_q     <= '0;
      buffered_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tiles_q    <= tiles_d;
      acc_q      <= acc_d;
      popped_q   <= popped_d;
      pipe_q     <= pipe_d;
      buffered_q <= buffered_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(buf_load && !buf_pop && (buffered_q == CW'(BUF_DEPTH))));

endmodule
